// File: rtl/e_muldiv_pkg.sv
// e_muldiv_pkg -- shared encodings and small decode helpers for the E-stage
// multiply/divide unit.
//   md_op_e    : operation codes emitted by CTRL for the md unit
//   md_state_e : IDLE/RUN sequencing state of e_muldiv
//   is_start() : op starts a multi-cycle operation
//   is_div()   : op uses the divide latency
// Optional feature macro: MULDIV_MADD_EN (MADD/MADDU/MSUB/MSUBU become
// start-type ops; otherwise those codes behave like MD_NONE).
package e_muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_start(input md_op_e op);
    logic s;
    s = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MULDIV_MADD_EN
    s = s || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return s;
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_muldiv_if.sv
// e_muldiv_if -- E-stage <-> multiply/divide unit signal bundle.
//   rd1, rd2  : forwarded rs/rt operands (32)
//   md_op     : md operation code (MD_NONE when E holds no md instruction)
//   start     : comb, start-type op accepted this cycle
//   busy      : registered, operation in flight
//   hilo_out  : comb, HI for MFHI, LO for MFLO, else 0
// master = pipeline side (drives operands/op), slave = e_muldiv.
interface e_muldiv_if
  import e_muldiv_pkg::*;
;
  logic [31:0] rd1;
  logic [31:0] rd2;
  md_op_e      md_op;
  logic        start;
  logic        busy;
  logic [31:0] hilo_out;

  modport master (output rd1, rd2, md_op, input start, busy, hilo_out);
  modport slave  (input rd1, rd2, md_op, output start, busy, hilo_out);
endinterface

// File: rtl/e_muldiv_md_calc.sv
// e_muldiv_md_calc -- combinational arithmetic for the md unit.
// Inputs : op_i (latched op), a_i/b_i (latched operands), hi_i/lo_i (current HI/LO)
// Outputs: hi_o/lo_o (result to write), we_o (result should be written)
// MADD family handled only when MULDIV_MADD_EN is defined.
module e_muldiv_md_calc
  import e_muldiv_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        we_o
);

  logic signed [31:0] a_s, b_s, q_s, r_s;
  logic signed [63:0] a_w, b_w, prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] prod_sb;

  assign a_s     = a_i;
  assign b_s     = b_i;
  assign a_w     = {{32{a_i[31]}}, a_i};
  assign b_w     = {{32{b_i[31]}}, b_i};
  assign prod_s  = a_w * b_w;
  assign prod_sb = prod_s;
  assign prod_u  = {32'd0, a_i} * {32'd0, b_i};
  assign q_s     = a_s / b_s;
  assign r_s     = a_s % b_s;

`ifdef MULDIV_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_i, lo_i};
`endif

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    we_o = 1'b0;
    case (op_i)
      MD_MULT:  begin {hi_o, lo_o} = prod_sb; we_o = 1'b1; end
      MD_MULTU: begin {hi_o, lo_o} = prod_u;  we_o = 1'b1; end
      MD_DIV: begin
        // Zero divisor leaves HI/LO untouched; the overflow case is pinned
        // explicitly rather than trusting the wrap of a signed divide.
        if (b_i != 32'd0) begin
          we_o = 1'b1;
          if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
            lo_o = 32'h8000_0000;
            hi_o = 32'd0;
          end else begin
            lo_o = q_s;
            hi_o = r_s;
          end
        end
      end
      MD_DIVU: begin
        if (b_i != 32'd0) begin
          we_o = 1'b1;
          lo_o = a_i / b_i;
          hi_o = a_i % b_i;
        end
      end
`ifdef MULDIV_MADD_EN
      MD_MADD:  begin {hi_o, lo_o} = acc + prod_sb; we_o = 1'b1; end
      MD_MADDU: begin {hi_o, lo_o} = acc + prod_u;  we_o = 1'b1; end
      MD_MSUB:  begin {hi_o, lo_o} = acc - prod_sb; we_o = 1'b1; end
      MD_MSUBU: begin {hi_o, lo_o} = acc - prod_u;  we_o = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_muldiv.sv
// e_muldiv -- multi-cycle multiply/divide unit with HI/LO, E stage.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset (aborts any operation in flight)
//   md     : e_muldiv_if.slave (rd1, rd2, md_op in; start, busy, hilo_out out)
// Parameters: MULT_CYCLES (mult/madd busy cycles), DIV_CYCLES (div busy cycles), both >= 1.
// Optional feature macro: MULDIV_MADD_EN (see e_muldiv_pkg).
module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input logic       clk,
  input logic       reset,
  e_muldiv_if.slave md
);

  localparam int MAXN  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      calc_hi, calc_lo;
  logic             calc_we;

  e_muldiv_md_calc u_calc (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (calc_hi),
    .lo_o (calc_lo),
    .we_o (calc_we)
  );

  assign md.busy     = (state_q == ST_RUN);
  assign md.start    = is_start(md.md_op) && (state_q == ST_IDLE);
  assign md.hilo_out = (md.md_op == MD_MFHI) ? hi_q :
                       (md.md_op == MD_MFLO) ? lo_q : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          state_d = ST_RUN;
          op_d    = md.md_op;
          a_d     = md.rd1;
          b_d     = md.rd2;
          cnt_d   = is_div(md.md_op) ? DIV_LOAD : MULT_LOAD;
        end else if (md.md_op == MD_MTHI) begin
          hi_d = md.rd1;
        end else if (md.md_op == MD_MTLO) begin
          lo_d = md.rd1;
        end
      end
      ST_RUN: begin
        // Counter only models latency; the result is ready from the latched
        // operands and is committed on the final busy edge.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (calc_we) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_e_muldiv.sv
// tb_e_muldiv -- directed self-checking bench for e_muldiv.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Define MULDIV_MADD_EN for both RTL and bench to exercise the MADD family.
module tb_e_muldiv;
  import e_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  e_muldiv_if md ();

  e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md.md_op = o;
    md.rd1   = a;
    md.rd2   = b;
    #1;
  endtask

  // Called after the start op has been driven; n0 busy cycles already seen.
  task automatic count_busy(input string tag, input int n0, input int exp_n);
    int n;
    bit done;
    n = n0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      md.md_op = MD_NONE;
      md.rd1   = '0;
      md.rd2   = '0;
      #1;
      if (md.busy) n++;
      else done = 1'b1;
    end
    if (!done) $display("FAIL %s_timeout: busy still high after 64 cycles", tag);
    chk_eq(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    drive(MD_MFHI, 32'd0, 32'd0);
    chk_eq({tag, "_hi"}, md.hilo_out, hi);
    drive(MD_MFLO, 32'd0, 32'd0);
    chk_eq({tag, "_lo"}, md.hilo_out, lo);
  endtask

  initial begin
    md.md_op = MD_NONE;
    md.rd1   = '0;
    md.rd2   = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_eq("rst_busy", 32'(md.busy), 32'd0);
    chk_eq("rst_start", 32'(md.start), 32'd0);
    md.md_op = MD_MFHI; #1;
    chk_eq("rst_hi", md.hilo_out, 32'd0);
    md.md_op = MD_MFLO; #1;
    chk_eq("rst_lo", md.hilo_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    md.md_op = MD_NONE;
    #1;
    chk_eq("none_hilo", md.hilo_out, 32'd0);

    // -3 * 5 = -15
    drive(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    chk_eq("mult_start", 32'(md.start), 32'd1);
    chk_eq("mult_busy0", 32'(md.busy), 32'd0);
    count_busy("mult_busy_n", 0, 5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // -7 / 2 = -3 rem -1
    drive(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk_eq("div_start", 32'(md.start), 32'd1);
    count_busy("div_busy_n", 0, 10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    drive(MD_DIVU, 32'd7, 32'd2);
    count_busy("divu_busy_n", 0, 10);
    chk_hilo("divu", 32'd1, 32'd3);

    drive(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy("divovf_busy_n", 0, 10);
    chk_hilo("divovf", 32'd0, 32'h8000_0000);

    drive(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy("multu_busy_n", 0, 5);
    chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    drive(MD_MULT, 32'h8000_0000, 32'h8000_0000);
    count_busy("multmin_busy_n", 0, 5);
    chk_hilo("multmin", 32'h4000_0000, 32'h0000_0000);

    // Divide by zero keeps HI/LO
    drive(MD_MTHI, 32'h1234, 32'd0);
    drive(MD_MTLO, 32'h5678, 32'd0);
    chk_hilo("mt", 32'h1234, 32'h5678);
    drive(MD_DIVU, 32'd99, 32'd0);
    chk_eq("div0_start", 32'(md.start), 32'd1);
    count_busy("div0_busy_n", 0, 10);
    chk_hilo("div0", 32'h1234, 32'h5678);

    // Reset during busy cycle 2 aborts the multiply
    drive(MD_MULT, 32'd3, 32'd4);
    drive(MD_NONE, 32'd0, 32'd0);
    chk_eq("abort_busy1", 32'(md.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_eq("abort_busy_now", 32'(md.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk_eq("abort_busy_later", 32'(md.busy), 32'd0);
    chk_hilo("abort", 32'd0, 32'd0);

    // Ops during busy are ignored
    drive(MD_MULT, 32'd7, 32'd9);
    drive(MD_MTLO, 32'h0000_AAAA, 32'd0);
    chk_eq("ign_mtlo_start", 32'(md.start), 32'd0);
    drive(MD_DIVU, 32'd100, 32'd3);
    chk_eq("ign_divu_start", 32'(md.start), 32'd0);
    count_busy("ign_busy_n", 2, 5);
    drive(MD_NONE, 32'd0, 32'd0);
    chk_eq("ign_no_restart", 32'(md.busy), 32'd0);
    chk_hilo("ign", 32'd0, 32'd63);

`ifdef MULDIV_MADD_EN
    drive(MD_MTHI, 32'd0, 32'd0);
    drive(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    drive(MD_MADDU, 32'd1, 32'd1);
    chk_eq("maddu_start", 32'(md.start), 32'd1);
    count_busy("maddu_busy_n", 0, 5);
    chk_hilo("maddu", 32'd1, 32'd0);
    drive(MD_MSUB, 32'd1, 32'd1);
    count_busy("msub_busy_n", 0, 5);
    chk_hilo("msub", 32'd0, 32'hFFFF_FFFF);
`else
    drive(MD_MTHI, 32'h11, 32'd0);
    drive(MD_MTLO, 32'h22, 32'd0);
    drive(MD_MADDU, 32'd1, 32'd1);
    chk_eq("maddu_off_start", 32'(md.start), 32'd0);
    drive(MD_NONE, 32'd0, 32'd0);
    chk_eq("maddu_off_busy", 32'(md.busy), 32'd0);
    chk_hilo("maddu_off", 32'h11, 32'h22);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
